hazard_control_unit: RTL and testbench

Parametrised successor hazard/stall controller for the RV32I pipeline. It resolves load-use and ID-stage branch/JALR data hazards and misprediction flushes. It also owns the multi-cycle (MUL/DIV) occupancy state machine internally, so the EX unit no longer supplies an external counter. It sits beside the ID stage and drives PC, IF/ID and ID/EX enables, bubble inserts, flush, and saturating stall/flush performance counters.

---
 rtl/hazard_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Stall/flush controller for the RV32I pipeline. It sits beside the ID stage
// and handles these cases, highest priority first:
//   - the MUL/DIV occupancy freeze (the multi-cycle state machine is owned here)
//   - ALU result feeding an ID-resolved branch/JALR
//   - load result feeding an ID-resolved branch/JALR
//   - classic load-use
//   - branch misprediction flush
// It also keeps saturating stall and flush event counters.
//
// Parameters
//   REG_W        register-address width
//   MUL_LATENCY  total EX occupancy of MUL-class ops (>= 2)
//   DIV_LATENCY  total EX occupancy of DIV/REM-class ops (>= 2)
//   CNT_W        performance counter width
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   idex_reg_write, idex_mem_read   ID/EX instruction writes rd / is a load
//   idex_rd                         ID/EX destination register
//   exmem_mem_read, exmem_rd        EX/MEM load flag and destination register
//   ifid_rs1, ifid_rs2              IF/ID source registers
//   id_branch, id_jalr              IF/ID holds a branch / JALR resolved in ID
//   id_resolve                      branch outcome valid this cycle
//   id_predicted, id_jump_taken     predicted and actual direction
//   ex_mc_start, ex_mc_div          multi-cycle op in EX; DIV (1) or MUL (0)
//   perf_clear                      clear both performance counters
//   pc_write, ifid_write,
//   idex_enable                     stage advance enables
//   bubble_id, bubble_mem           zero control entering ID/EX / EX/MEM
//   flush                           squash the IF/ID instruction
//   mc_busy                         registered: state machine is in BUSY
//   mc_done                         last occupancy cycle of the multi-cycle op
//   stall_count, flush_count        saturating event counters
// -----------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int REG_W       = 5,
  parameter int MUL_LATENCY = 6,
  parameter int DIV_LATENCY = 7,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_reg_write,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             exmem_mem_read,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             id_branch,
  input  logic             id_jalr,
  input  logic             id_resolve,
  input  logic             id_predicted,
  input  logic             id_jump_taken,
  input  logic             ex_mc_start,
  input  logic             ex_mc_div,
  input  logic             perf_clear,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_enable,
  output logic             bubble_id,
  output logic             bubble_mem,
  output logic             flush,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  // The counter is loaded with LAT-2 at most, so it never has to hold MAX_LAT.
  localparam int MC_W = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [MC_W-1:0]  MUL_INIT = MC_W'(MUL_LATENCY - 2);
  localparam logic [MC_W-1:0]  DIV_INIT = MC_W'(DIV_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  mc_state_e        state_q, state_d;
  logic [MC_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Hazard conditions. x0 is hard-wired to zero, so it never creates a
  // dependency.
  logic br;
  logic idex_match, exmem_match;
  logic freeze, alu_br, load_br, load_use, mispredict;

  assign br          = id_branch | id_jalr;
  assign idex_match  = (idex_rd  != '0) & ((idex_rd  == ifid_rs1) | (idex_rd  == ifid_rs2));
  assign exmem_match = (exmem_rd != '0) & ((exmem_rd == ifid_rs1) | (exmem_rd == ifid_rs2));

  assign freeze     = ((state_q == IDLE) & ex_mc_start) | ((state_q == BUSY) & (cnt_q != '0));
  assign alu_br     = idex_reg_write & br & idex_match;
  assign load_br    = exmem_mem_read & br & exmem_match;
  assign load_use   = idex_mem_read & idex_match;
  assign mispredict = id_resolve & (id_predicted ^ id_jump_taken);

  always_comb begin
    // NOTE: every output and next-state signal gets a default before any branch,
    // so no path through the block leaves a value unassigned (no latches).
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_enable = 1'b1;
    bubble_id   = 1'b0;
    bubble_mem  = 1'b0;
    flush       = 1'b0;
    mc_done     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    // One action per cycle. Flush is the lowest priority, so a mispredicted
    // branch held by a stall re-resolves once the stall clears.
    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_enable = 1'b0;
      bubble_mem  = 1'b1;
    end else if (alu_br | load_br | load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble_id  = 1'b1;
    end else if (mispredict) begin
      flush = 1'b1;
    end

    // Occupancy: start cycle + (LAT-2) counting cycles + one done cycle.
    unique case (state_q)
      IDLE: begin
        if (ex_mc_start) begin
          state_d = BUSY;
          cnt_d   = ex_mc_div ? DIV_INIT : MUL_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - MC_W'(1);
        end else begin
          mc_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counters saturate instead of wrapping; a clear beats an increment.
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (perf_clear) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (!pc_write && stall_count_q != CNT_MAX) stall_count_d = stall_count_q + CNT_W'(1);
      if (flush && flush_count_q != CNT_MAX)     flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values that were present before the edge.
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign mc_busy     = (state_q == BUSY);
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Directed bench for hazard_control_unit. It uses a 4-bit counter width so
// that saturation can be reached quickly. The outputs are packed into one
// vector in this order:
//   {pc_write, ifid_write, idex_enable, bubble_id, bubble_mem, flush,
//    mc_busy, mc_done}
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  // Expected output vectors.
  localparam logic [7:0] V_DEF    = 8'b1110_0000;
  localparam logic [7:0] V_STALL  = 8'b0011_0000;
  localparam logic [7:0] V_FLUSH  = 8'b1110_0100;
  localparam logic [7:0] V_START  = 8'b0000_1000;
  localparam logic [7:0] V_BUSY   = 8'b0000_1010;
  localparam logic [7:0] V_DONE   = 8'b1110_0011;

  logic             clk = 1'b0;
  logic             reset;
  logic             idex_reg_write, idex_mem_read;
  logic [REG_W-1:0] idex_rd;
  logic             exmem_mem_read;
  logic [REG_W-1:0] exmem_rd;
  logic [REG_W-1:0] ifid_rs1, ifid_rs2;
  logic             id_branch, id_jalr, id_resolve, id_predicted, id_jump_taken;
  logic             ex_mc_start, ex_mc_div, perf_clear;
  logic             pc_write, ifid_write, idex_enable, bubble_id, bubble_mem, flush;
  logic             mc_busy, mc_done;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [7:0]       outs;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_control_unit #(
    .REG_W(REG_W), .MUL_LATENCY(6), .DIV_LATENCY(7), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .id_branch(id_branch), .id_jalr(id_jalr), .id_resolve(id_resolve),
    .id_predicted(id_predicted), .id_jump_taken(id_jump_taken),
    .ex_mc_start(ex_mc_start), .ex_mc_div(ex_mc_div), .perf_clear(perf_clear),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_enable(idex_enable),
    .bubble_id(bubble_id), .bubble_mem(bubble_mem), .flush(flush),
    .mc_busy(mc_busy), .mc_done(mc_done),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  assign outs = {pc_write, ifid_write, idex_enable, bubble_id, bubble_mem, flush, mc_busy, mc_done};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and move just past the edge; inputs are then changed
  // and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    idex_reg_write = 1'b0; idex_mem_read = 1'b0; idex_rd = '0;
    exmem_mem_read = 1'b0; exmem_rd = '0;
    ifid_rs1 = '0; ifid_rs2 = '0;
    id_branch = 1'b0; id_jalr = 1'b0; id_resolve = 1'b0;
    id_predicted = 1'b0; id_jump_taken = 1'b0;
    ex_mc_start = 1'b0; ex_mc_div = 1'b0; perf_clear = 1'b0;
  endtask

  // Run one multi-cycle op of total occupancy lat. The start cycle also
  // presents a load-use hazard and a mispredict, which the freeze must
  // override.
  task automatic run_mc(input logic div, input int lat);
    logic [7:0] exp;
    for (int c = 1; c <= lat; c++) begin
      if (c == 1) begin
        ex_mc_start = 1'b1; ex_mc_div = div;
        idex_mem_read = 1'b1; idex_rd = 5'd9; ifid_rs1 = 5'd9;
        id_resolve = 1'b1; id_jump_taken = 1'b1;
      end else begin
        clear_in();
      end
      #1;
      exp = (c == 1) ? V_START : (c < lat) ? V_BUSY : V_DONE;
      check($sformatf("mc_lat%0d_cycle%0d", lat, c), 32'(outs), 32'(exp));
      tick();
    end
    exp_stall += lat - 1;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    #1;
    check("reset_outs", 32'(outs), 32'(V_DEF));
    check("reset_stall_cnt", 32'(stall_count), 0);
    check("reset_flush_cnt", 32'(flush_count), 0);

    // Load-use via rs2.
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5;
    #1 check("load_use", 32'(outs), 32'(V_STALL));
    tick(); exp_stall++;
    clear_in();
    #1 check("load_use_released", 32'(outs), 32'(V_DEF));
    check("load_use_stall_cnt", 32'(stall_count), 32'(exp_stall));

    // rd = x0 never creates a hazard.
    idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0;
    #1 check("rd0_guard", 32'(outs), 32'(V_DEF));
    tick();
    clear_in();
    #1 check("rd0_stall_cnt", 32'(stall_count), 32'(exp_stall));

    // Load in EX/MEM feeding a JALR.
    exmem_mem_read = 1'b1; exmem_rd = 5'd3; id_jalr = 1'b1; ifid_rs1 = 5'd3;
    #1 check("load_branch", 32'(outs), 32'(V_STALL));
    tick(); exp_stall++;
    id_jalr = 1'b0;
    #1 check("load_no_branch", 32'(outs), 32'(V_DEF));
    tick();
    clear_in();

    // ALU result feeding a mispredicted branch: stall first, flush next cycle.
    idex_reg_write = 1'b1; idex_rd = 5'd7; id_branch = 1'b1; ifid_rs1 = 5'd7;
    id_resolve = 1'b1; id_predicted = 1'b0; id_jump_taken = 1'b1;
    #1 check("alu_branch_stall", 32'(outs), 32'(V_STALL));
    tick(); exp_stall++;
    idex_reg_write = 1'b0;
    #1 check("mispredict_flush", 32'(outs), 32'(V_FLUSH));
    tick(); exp_flush++;
    id_predicted = 1'b1;
    #1 check("correct_predict", 32'(outs), 32'(V_DEF));
    tick();
    clear_in();
    #1;
    check("branch_stall_cnt", 32'(stall_count), 32'(exp_stall));
    check("branch_flush_cnt", 32'(flush_count), 32'(exp_flush));

    // MUL, then DIV started in the cycle right after mc_done.
    run_mc(1'b0, 6);
    run_mc(1'b1, 7);
    #1;
    check("mc_back_to_idle", 32'(outs), 32'(V_DEF));
    check("mc_stall_cnt", 32'(stall_count), 32'(exp_stall));
    check("mc_flush_cnt", 32'(flush_count), 32'(exp_flush));

    // Reset during the third BUSY cycle aborts the op.
    ex_mc_start = 1'b1;
    tick();
    clear_in();
    tick();
    tick();
    #1 check("busy3_before_reset", 32'(outs), 32'(V_BUSY));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("reset_mid_busy_outs", 32'(outs), 32'(V_DEF));
    check("reset_mid_busy_stall", 32'(stall_count), 0);
    check("reset_mid_busy_flush", 32'(flush_count), 0);

    // One flush, then saturate the stall counter.
    id_resolve = 1'b1; id_predicted = 1'b1; id_jump_taken = 1'b0;
    tick();
    clear_in();
    #1 check("flush_cnt_one", 32'(flush_count), 1);
    idex_mem_read = 1'b1; idex_rd = 5'd12; ifid_rs1 = 5'd12;
    for (int i = 0; i < 20; i++) tick();
    #1;
    check("sat_stall_outs", 32'(outs), 32'(V_STALL));
    check("sat_stall_cnt", 32'(stall_count), 15);

    // A clear wins over an increment in the same cycle.
    perf_clear = 1'b1;
    tick();
    clear_in();
    #1;
    check("clear_stall_cnt", 32'(stall_count), 0);
    check("clear_flush_cnt", 32'(flush_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
